uart_tx_buf_hs: RTL

Buffered high-speed UART transmitter, 8N1, LSB first, fixed divisor of BPS_CNT system clocks per bit (50 MHz / 25 = 2 Mbps).
- Host logic writes bytes into an internal FIFO with single-cycle strobes.
- The transmit engine drains the FIFO back-to-back onto uart_txd with no idle gap between frames.
- Counterpart of the uart_hs receive path; lets CPU/debug logic burst bytes without waiting per frame.

---
 rtl/uart_tx_buf_hs_if.sv | 27 ++
 rtl/uart_tx_buf_hs.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf_hs_if.sv
// Host-side bus of the buffered UART transmitter: write strobe, status, serial line.
// Latency: none; bundle of wires only.
// Backpressure: host must watch tx_full; writes while full are dropped and flagged.
interface uart_tx_buf_hs_if #(
  parameter int FIFO_AW = 4
);
  logic             tx_wr;
  logic [7:0]       tx_data;
  logic             tx_ovf_clr;
  logic             tx_full;
  logic [FIFO_AW:0] tx_count;
  logic             tx_busy;
  logic             tx_overflow;
  logic             uart_txd;

  // Host / CPU side
  modport master (
    output tx_wr, tx_data, tx_ovf_clr,
    input  tx_full, tx_count, tx_busy, tx_overflow, uart_txd
  );

  // Transmitter side
  modport slave (
    input  tx_wr, tx_data, tx_ovf_clr,
    output tx_full, tx_count, tx_busy, tx_overflow, uart_txd
  );
endinterface

// File: rtl/uart_tx_buf_hs.sv
// Buffered 8N1 UART transmitter, LSB first, BPS_CNT clocks per bit, frames sent back-to-back.
// Latency: byte written into an empty FIFO with the engine idle starts its start bit one clock later.
// Backpressure: none towards host beyond tx_full; writes while full are dropped and set tx_overflow.
module uart_tx_buf_hs #(
  parameter int BPS_CNT = 25,
  parameter int FIFO_AW = 4
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  uart_tx_buf_hs_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic [FIFO_AW:0] DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [7:0]       BIT_LAST = 8'(BPS_CNT - 1);

  // FIFO storage; contents are don't-care after reset since pointers restart
  logic [7:0]         mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  state_e             state_q, state_d;
  logic [7:0]         bit_cnt_q, bit_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;

  logic               full;
  logic               wr_acc;
  logic               wr_drop;
  logic               pop;
  logic               bit_end;
  logic               have_data;

  // Next-state for FIFO bookkeeping and the serialiser; full is judged on registered count
  always_comb begin
    full      = (count_q == DEPTH);
    wr_acc    = bus.tx_wr && !full;
    wr_drop   = bus.tx_wr && full;
    bit_end   = (bit_cnt_q == BIT_LAST);
    have_data = (count_q != '0);

    pop       = 1'b0;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    case (state_q)
      IDLE: begin
        if (have_data) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          // Chain straight into the next start bit so queued frames have no idle gap
          if (have_data) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level is registered and derived from where the engine will be next cycle
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[bit_idx_d];
      default: txd_d = 1'b1;
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;

    count_d = count_q;
    if (wr_acc && !pop) count_d = count_q + 1'b1;
    if (!wr_acc && pop) count_d = count_q - 1'b1;

    // A dropped write outranks a clear in the same cycle
    ovf_d = ovf_q;
    if (wr_drop)             ovf_d = 1'b1;
    else if (bus.tx_ovf_clr) ovf_d = 1'b0;
  end

  // State, pointer and line registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage write port
  always_ff @(posedge sys_clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= bus.tx_data;
    end
  end

  assign bus.tx_full     = full;
  assign bus.tx_count    = count_q;
  assign bus.tx_busy     = have_data || (state_q != IDLE);
  assign bus.tx_overflow = ovf_q;
  assign bus.uart_txd    = txd_q;

endmodule
